// File: rtl/nco_phase_gen.sv
// Phase generator for the unrolled sine block: emits UNR lanes base+k*FTW per cycle, base advancing by UNR*FTW.
// First vector two cycles after start; FTW accepted only in IDLE (ftw_ready), no output backpressure.
module nco_phase_gen #(
  parameter int DWIDTH = 14,
  parameter int UNR    = 4,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] ftw_in,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  input  logic [DWIDTH-1:0] phase_in,
  input  logic [CNTW-1:0]   burst_len,
  input  logic              start,
  input  logic              stop,
  output logic [DWIDTH-1:0] dout [UNR],
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DWIDTH-1:0] ftw_q;
  logic [DWIDTH-1:0] base_q;
  logic [DWIDTH-1:0] step_q;
  logic [DWIDTH-1:0] off_q [UNR];
  logic [CNTW-1:0]   len_q;
  logic [CNTW-1:0]   cnt_q;
  logic              burst_end;
  logic              emit;

  // len_q == 0 means free-running; the counter is then frozen so it can never alias a length
  assign burst_end = (len_q != '0) && (cnt_q == len_q);
  assign emit      = (state == RUN) && !stop && !burst_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = stop ? DONE : RUN;
      RUN:     if (stop || burst_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ftw_ready = (state == IDLE);
    busy      = (state == LOAD) || (state == RUN);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ftw_q      <= '0;
      base_q     <= '0;
      step_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      dout_valid <= 1'b0;
      for (int k = 0; k < UNR; k++) begin
        off_q[k] <= '0;
        dout[k]  <= '0;
      end
    end else begin
      if ((state == IDLE) && ftw_valid) begin
        ftw_q <= ftw_in;
      end
      if ((state == IDLE) && start) begin
        base_q <= phase_in;
        len_q  <= burst_len;
        cnt_q  <= '0;
      end
      // Lane offsets and the per-cycle step are fixed for the whole burst
      if (state == LOAD) begin
        for (int k = 0; k < UNR; k++) begin
          off_q[k] <= ftw_q * DWIDTH'(k);
        end
        step_q <= ftw_q * DWIDTH'(UNR);
      end
      dout_valid <= emit;
      if (emit) begin
        for (int k = 0; k < UNR; k++) begin
          dout[k] <= base_q + off_q[k];
        end
        base_q <= base_q + step_q;
        if (len_q != '0) begin
          cnt_q <= cnt_q + CNTW'(1);
        end
      end
    end
  end

  a_done_quiet: assert property (@(posedge clk) disable iff (!reset_n) done |-> !dout_valid);

endmodule
